// File: rtl/aes_v2_mix_size_pkg.sv
// Shared AES definitions: GF(2^8) reduction constant, MixColumns coefficients,
// operand byte positions and the xtime / constant-multiply helpers.
package aes_v2_mix_size_pkg;

  localparam logic [7:0] GF_POLY = 8'h1b;

  // Coefficient for a_(i+k) sits in nibble k.
  localparam logic [15:0] MIX_FWD_COEF = {4'h1, 4'h1, 4'h3, 4'h2};
  localparam logic [15:0] MIX_INV_COEF = {4'h9, 4'hd, 4'hb, 4'he};

  localparam int A0_LSB = 0;
  localparam int A1_LSB = 8;
  localparam int A2_LSB = 16;
  localparam int A3_LSB = 24;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
  endfunction

  // Multiply by a constant below 16 as a sum of a, 2a, 4a, 8a.
  function automatic logic [7:0] gf_mul_c(input logic [7:0] a, input logic [3:0] c);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return ({8{c[0]}} & a) ^ ({8{c[1]}} & x2) ^ ({8{c[2]}} & x4) ^ ({8{c[3]}} & x8);
  endfunction

endpackage

// File: rtl/aes_v2_mix_size_byte.sv
// One MixColumns output byte from a rotated column; the inverse product-sum is
// only built when AES_V2_MIX_INV_EN is defined, otherwise enc=0 yields 8'h00.
module aes_mix_byte
  import aes_v2_mix_size_pkg::*;
(
  input  logic [7:0] a_0,
  input  logic [7:0] a_1,
  input  logic [7:0] a_2,
  input  logic [7:0] a_3,
  input  logic       enc,
  output logic [7:0] r
);

  logic [7:0] fwd;

  assign fwd = gf_mul_c(a_0, MIX_FWD_COEF[3:0])   ^ gf_mul_c(a_1, MIX_FWD_COEF[7:4]) ^
               gf_mul_c(a_2, MIX_FWD_COEF[11:8])  ^ gf_mul_c(a_3, MIX_FWD_COEF[15:12]);

`ifdef AES_V2_MIX_INV_EN
  logic [7:0] inv;

  assign inv = gf_mul_c(a_0, MIX_INV_COEF[3:0])   ^ gf_mul_c(a_1, MIX_INV_COEF[7:4]) ^
               gf_mul_c(a_2, MIX_INV_COEF[11:8])  ^ gf_mul_c(a_3, MIX_INV_COEF[15:12]);
  assign r   = enc ? fwd : inv;
`else
  assign r   = enc ? fwd : 8'h00;
`endif

endmodule

// File: rtl/aes_v2_mix_size.sv
// Size-optimised MixColumns / InvMixColumns: one output byte per cycle over four
// cycles through a single byte datapath. Inverse gated by AES_V2_MIX_INV_EN.
module aes_v2_mix_size
  import aes_v2_mix_size_pkg::*;
(
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        valid,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        enc,
  output logic        ready,
  output logic [31:0] rd
);

  localparam logic [1:0] S0 = 2'd0;
  localparam logic [1:0] S1 = 2'd1;
  localparam logic [1:0] S2 = 2'd2;
  localparam logic [1:0] S3 = 2'd3;

  logic [1:0] fsm;
  logic [1:0] fsm_nxt;
  logic [7:0] a0, a1, a2, a3;
  logic [7:0] m0, m1, m2, m3;
  logic [7:0] r_byte;
  logic [7:0] b_0, b_1, b_2;
  logic       unused_bits;

  assign a0 = rs1[A0_LSB +: 8];
  assign a1 = rs1[A1_LSB +: 8];
  assign a2 = rs2[A2_LSB +: 8];
  assign a3 = rs2[A3_LSB +: 8];

  assign unused_bits = ^{rs1[31:16], rs2[15:0]};

  // Rotate the column so the datapath always sees a_i in slot 0.
  always_comb begin
    {m0, m1, m2, m3} = {a0, a1, a2, a3};
    case (fsm)
      S1:      {m0, m1, m2, m3} = {a1, a2, a3, a0};
      S2:      {m0, m1, m2, m3} = {a2, a3, a0, a1};
      S3:      {m0, m1, m2, m3} = {a3, a0, a1, a2};
      default: {m0, m1, m2, m3} = {a0, a1, a2, a3};
    endcase
  end

  aes_mix_byte u_mix_byte (
    .a_0 (m0),
    .a_1 (m1),
    .a_2 (m2),
    .a_3 (m3),
    .enc (enc),
    .r   (r_byte)
  );

  // Counter wraps S3->S0 so a held valid starts the next instruction at once.
  assign fsm_nxt = valid ? fsm + 2'd1 : S0;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      fsm <= S0;
    end else begin
      fsm <= fsm_nxt;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      b_0 <= 8'h00;
      b_1 <= 8'h00;
      b_2 <= 8'h00;
    end else if (valid) begin
      if (fsm == S0) b_0 <= r_byte;
      if (fsm == S1) b_1 <= r_byte;
      if (fsm == S2) b_2 <= r_byte;
    end
  end

  assign ready = (fsm == S3) & valid;
  assign rd    = {r_byte, b_2, b_1, b_0};

endmodule

// File: tb/tb_aes_v2_mix_size.sv
// Directed bench for aes_v2_mix_size: reset, FIPS vectors, fixed points,
// back-to-back issue, abort and asynchronous reset mid-operation.
module tb_aes_v2_mix_size;

  logic        g_clk;
  logic        g_resetn;
  logic        valid;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        enc;
  logic        ready;
  logic [31:0] rd;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef AES_V2_MIX_INV_EN
  localparam logic [31:0] EXP_INV_FIPS = 32'h455313db;
  localparam logic [31:0] EXP_INV_C6   = 32'hc6c6c6c6;
`else
  localparam logic [31:0] EXP_INV_FIPS = 32'h00000000;
  localparam logic [31:0] EXP_INV_C6   = 32'h00000000;
`endif

  aes_v2_mix_size dut (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .valid    (valid),
    .rs1      (rs1),
    .rs2      (rs2),
    .enc      (enc),
    .ready    (ready),
    .rd       (rd)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Entered in a cycle where fsm is S0; returns one cycle after the ready cycle.
  task automatic run_op(input string tag, input logic [31:0] s1, input logic [31:0] s2,
                        input logic e, input logic [31:0] exp_rd, input logic keep);
    rs1   = s1;
    rs2   = s2;
    enc   = e;
    valid = 1'b1;
    #1;
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) begin
        @(negedge g_clk);
        #1;
      end
      if (k < 4) begin
        chk({tag, "_busy"}, {31'b0, ready}, 32'd0);
      end else begin
        chk({tag, "_ready"}, {31'b0, ready}, 32'd1);
        chk({tag, "_rd"}, rd, exp_rd);
      end
    end
    if (!keep) valid = 1'b0;
    @(negedge g_clk);
    #1;
  endtask

  initial begin
    g_resetn = 1'b0;
    valid    = 1'b0;
    rs1      = 32'h0;
    rs2      = 32'h0;
    enc      = 1'b1;

    @(negedge g_clk);
    #1;
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_bregs", {8'h00, rd[23:0]}, 32'h0);
    chk("rst_fsm", {30'b0, dut.fsm}, 32'd0);
    g_resetn = 1'b1;
    #1;

    run_op("fwd_fips", 32'h000013db, 32'h45530000, 1'b1, 32'hbca14d8e, 1'b0);
    run_op("inv_fips", 32'h00004d8e, 32'hbca10000, 1'b0, EXP_INV_FIPS, 1'b0);
    run_op("fwd_c6",   32'h0000c6c6, 32'hc6c60000, 1'b1, 32'hc6c6c6c6, 1'b0);
    run_op("fwd_01",   32'h00000101, 32'h01010000, 1'b1, 32'h01010101, 1'b0);
    run_op("inv_c6",   32'h0000c6c6, 32'hc6c60000, 1'b0, EXP_INV_C6,   1'b0);

    // Back-to-back with valid held
    run_op("b2b_1", 32'h00000af2, 32'h5c220000, 1'b1, 32'h9d58dc9f, 1'b1);
    run_op("b2b_2", 32'h000013db, 32'h45530000, 1'b1, 32'hbca14d8e, 1'b0);

    // Abort in S2, then reissue a different column
    rs1   = 32'h0000c6c6;
    rs2   = 32'hc6c60000;
    enc   = 1'b1;
    valid = 1'b1;
    #1;
    @(negedge g_clk);
    #1;
    @(negedge g_clk);
    #1;
    chk("abort_in_s2", {30'b0, dut.fsm}, 32'd2);
    valid = 1'b0;
    #1;
    chk("abort_ready", {31'b0, ready}, 32'd0);
    @(negedge g_clk);
    #1;
    chk("abort_fsm0", {30'b0, dut.fsm}, 32'd0);
    run_op("reissue", 32'h00000af2, 32'h5c220000, 1'b1, 32'h9d58dc9f, 1'b0);

    // Asynchronous reset in S1
    rs1   = 32'h000013db;
    rs2   = 32'h45530000;
    enc   = 1'b1;
    valid = 1'b1;
    #1;
    @(negedge g_clk);
    #1;
    chk("pre_rst_fsm", {30'b0, dut.fsm}, 32'd1);
    g_resetn = 1'b0;
    #1;
    chk("midrst_fsm", {30'b0, dut.fsm}, 32'd0);
    chk("midrst_ready", {31'b0, ready}, 32'd0);
    chk("midrst_bregs", {8'h00, rd[23:0]}, 32'h0);
    @(negedge g_clk);
    #1;
    g_resetn = 1'b1;
    #1;
    run_op("post_rst", 32'h000013db, 32'h45530000, 1'b1, 32'hbca14d8e, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_v2_mix_size.md
# aes_v2_mix_size

Size-optimised AES MixColumns unit for the lightweight v2 AES instructions. It sits directly downstream of the SubBytes stage and consumes the bytes that stage writes back. It computes one 32-bit MixColumns or InvMixColumns column over four cycles, using a single byte-wide GF(2^8) multiply-accumulate datapath and saving intermediate output bytes in registers. It uses the same valid/ready single-issue handshake as the other v2 AES instruction units.

## Interface
- No parameters.
- g_clk  input  1  clock; all state updates on rising edge.
- g_resetn  input  1  reset; asynchronous, active-low.
- valid  input  1  operands valid; held high with stable operands until ready.
- rs1  input  32  source register 1; supplies column bytes a0=rs1[7:0], a1=rs1[15:8].
- rs2  input  32  source register 2; supplies column bytes a2=rs2[23:16], a3=rs2[31:24].
- enc  input  1  1: forward MixColumns; 0: InvMixColumns.
- ready  output  1  result valid this cycle; instruction completes.
- rd  output  32  result column {r3,r2,r1,r0}.

## Operation
- Byte i result, indices mod 4:
  - Forward: r_i = 2·a_i ^ 3·a_(i+1) ^ a_(i+2) ^ a_(i+3).
  - Inverse: r_i = e·a_i ^ b·a_(i+1) ^ d·a_(i+2) ^ 9·a_(i+3).
  - Arithmetic is GF(2^8) modulo x^8+x^4+x^3+x+1 (xtime reduction constant 0x1b).
- The 2-bit counter fsm selects i, giving the rotation of {a0..a3} fed to the byte datapath.
- States and transitions:
  - S0 (fsm=0): compute r0; latch into b_0 when valid.
  - S1: compute r1; latch into b_1.
  - S2: compute r2; latch into b_2.
  - S3: compute r3 combinationally; ready=1; rd={r3,b_2,b_1,b_0}.
- fsm advances by 1 per cycle while valid=1. At S3 with valid=1, it returns to S0 on the next edge, so back-to-back instructions are allowed.
- Abort: valid=0 in any state forces fsm to S0 next cycle. b_* hold their value and are always rewritten before reuse.
- ready = (fsm==3) & valid. rd is don't-care when ready=0, but is always driven (no X) from current registers and datapath.
- enc is sampled every cycle and must be stable while valid is high.

## Timing
- Reset (async assert) sets: fsm=S0, b_0=b_1=b_2=8'h00, ready=0.
- Latency is exactly 4 cycles from valid rising: ready is high in the 4th cycle, combinationally from fsm and valid.
- Throughput: one instruction per 4 cycles with valid held continuously.
- Reset asserted mid-operation: immediate return to S0 and ready=0. After release, the pending instruction restarts from S0 and takes a full 4 cycles.
- No combinational path from rs1, rs2 or enc to ready. There is a combinational path from them to rd.

## Configuration
- AES_V2_MIX_INV_EN defined: inverse datapath present; enc=0 performs InvMixColumns.
- Not defined: only the forward multipliers (x2, x3) are built. With enc=0 the unit still handshakes with 4-cycle latency but returns rd=32'h0. Area is reduced.

## Structure
- Shared AES package holds:
  - GF reduction constant 8'h1b.
  - Forward coefficients {2,3,1,1} and inverse coefficients {e,b,d,9}.
  - Byte-select index constants.
  - The xtime function, shared with other AES units.
- One sub-module, aes_mix_byte: combinational; inputs four bytes and enc; output one product-sum byte; its inverse logic is guarded by AES_V2_MIX_INV_EN.
- Top level contains the fsm, operand rotation mux, b_0 to b_2 and result assembly.

## Test plan
- Forward, FIPS-197 vector: rs1=32'h000013db, rs2=32'h45530000, enc=1 -> ready in cycle 4, rd=32'hbca14d8e.
- Inverse, same column reversed: rs1=32'h00004d8e, rs2=32'hbca10000, enc=0 -> rd=32'h455313db. With the macro undefined -> rd=32'h0.
- Fixed points: rs1=32'h0000c6c6, rs2=32'hc6c60000, enc=1 -> rd=32'hc6c6c6c6. Same for bytes 8'h01 -> rd=32'h01010101.
- Back-to-back:
  - Stimulus: valid held high; vector f2 0a 22 5c (rs1=32'h00000af2, rs2=32'h5c220000), then the FIPS vector.
  - Required: rd=32'h9d58dc9f in cycle 4, rd=32'hbca14d8e in cycle 8, no idle cycle between.
- Abort: drop valid in S2, then reissue -> ready is not seen until 4 cycles after the reissue, and the result is correct.
- Reset mid-op: assert g_resetn=0 asynchronously in S1 -> fsm=0 and ready=0 immediately. After release, the full 4-cycle result is correct.
